sm3_msg_arb: RTL and testbench
==============================

Name: sm3_msg_arb

Overview:
- Shares one SM3 hashing pipeline (pad, expand and compress cores) between REQ_NUM independent message sources.
- Grants the message input bus to one requester at a time, using round-robin order.
- Holds the grant for the whole message, up to and including the beat with lst.
- Waits for the compress core's final digest, then returns that digest to the owning requester, tagged with its id.
- Sits between the system-side requesters and the pad core's msg_inpt_* bus.

Parameters:
- REQ_NUM, 4: number of requesters (2..8).
- INPT_DW, 32: message bus width in bits (32 or 64); must match the SM3_INPT_DW_32/SM3_INPT_DW_64 build define.
- ID_W, $clog2(REQ_NUM): width of the requester id.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_vld  in  REQ_NUM  per-requester message beat valid.
- req_d  in  REQ_NUM*INPT_DW  per-requester beat data, requester i at slice [i*INPT_DW +: INPT_DW].
- req_vld_byte  in  REQ_NUM*INPT_DW/8  per-requester valid-byte mask, MSB = first byte.
- req_lst  in  REQ_NUM  last beat of the message.
- req_rdy  out  REQ_NUM  beat accepted when req_vld & req_rdy.
- msg_inpt_vld  out  1  to pad core.
- msg_inpt_d  out  INPT_DW  to pad core.
- msg_inpt_vld_byte  out  INPT_DW/8  to pad core.
- msg_inpt_lst  out  1  to pad core.
- msg_inpt_rdy  in  1  pad core can accept a beat.
- cmprss_otpt_vld  in  1  one-cycle pulse, final digest valid.
- cmprss_otpt_res  in  256  final digest.
- res_vld  out  1  digest available to requester.
- res_d  out  256  digest.
- res_id  out  ID_W  owning requester.
- res_rdy  in  1  requester side accepts the digest.
- busy  out  1  state != IDLE.
- err_unexp_res  out  1  one-cycle pulse: cmprss_otpt_vld seen outside WAIT.

Behaviour:
- State machine has four states: IDLE, XFER, WAIT, RESP (2-bit encoding).
- Reset:
  - state = IDLE, rr_ptr = 0, gnt_id = 0, res_d = 0.
  - All outputs 0: msg_inpt_*, req_rdy, res_*, busy, err_unexp_res.
  - The top level resets the SM3 cores from the same rst; reset mid-message abandons that message silently.
- IDLE:
  - If any req_vld is set, select the first asserted requester scanning rr_ptr, rr_ptr+1, ... modulo REQ_NUM.
  - Register the selection into gnt_id and go to XFER on the next cycle.
  - Grant latency is 1 cycle; no beat is accepted in IDLE.
- XFER:
  - msg_inpt_vld, msg_inpt_d, msg_inpt_vld_byte and msg_inpt_lst are combinationally muxed from requester gnt_id.
  - req_rdy[gnt_id] = msg_inpt_rdy; all other req_rdy bits are 0.
  - req_vld deasserting mid-message is a legal bubble; the grant is held.
  - On msg_inpt_vld & msg_inpt_rdy & msg_inpt_lst, go to WAIT.
  - Requests from other requesters are ignored until the next IDLE.
- WAIT:
  - All msg_inpt_* outputs are 0.
  - On cmprss_otpt_vld, capture cmprss_otpt_res into res_d and go to RESP.
- RESP:
  - res_vld = 1; res_id = gnt_id; res_d is held stable.
  - On res_vld & res_rdy, go to IDLE and set rr_ptr = gnt_id+1, wrapping REQ_NUM-1 to 0.
  - A response may be held off indefinitely.
- Unexpected digest: cmprss_otpt_vld in IDLE, XFER or RESP pulses err_unexp_res for 1 cycle. res_d is not overwritten and the state is unchanged.
- Simultaneous requests: the round-robin order decides; a requester just served has the lowest priority.
- Single-beat message (vld and lst together in the first XFER cycle): XFER lasts exactly 1 cycle if msg_inpt_rdy = 1.
- Minimum turnaround between back-to-back messages from different requesters is 2 cycles: the RESP accept cycle plus the IDLE cycle.
- The block does not inspect data or lengths; padding is entirely the pad core's job.

Decomposition:
- Shared package sm3_pkg holds:
  - the state typedef (IDLE/XFER/WAIT/RESP);
  - SM3_DGST_W = 256;
  - the INPT_DW default derived from the sm3_cfg.v define.
- One sub-module: sm3_rr_sel, a combinational round-robin picker with inputs req vector and rr_ptr and outputs id and found.
- The FSM, muxing and digest register live in sm3_msg_arb.

Test Plan:
- Requester 0 sends 'abc': one beat d=32'h61626300, vld_byte=4'b1110, lst=1.
  - Expect res_id=0 and res_d=256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0.
- Requester 2 sends 16 beats of 32'h61626364 with vld_byte=4'hF, lst on beat 16.
  - Expect res_id=2 and res_d=256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732.
- Requesters 0, 1 and 3 all raise req_vld in the same cycle with rr_ptr=0.
  - Expect grant order 0, 1, 3, then 0 again on re-request.
  - Expect req_rdy of non-granted requesters to stay 0 throughout.
- Backpressure case:
  - Toggle msg_inpt_rdy randomly 50% and insert req_vld bubbles during the 16-beat message.
  - Expect the beat count at the pad core to equal 16, lst accepted exactly once, and the digest unchanged from the 16-beat scenario.
- Response hold: keep res_rdy=0 for 20 cycles in RESP.
  - Expect res_vld and res_d stable, and a new req_vld not granted.
  - After res_rdy=1, expect IDLE followed by a grant on the next cycle.
- Error and reset:
  - Pulse cmprss_otpt_vld during XFER: expect an err_unexp_res single pulse and the state still XFER.
  - Assert rst mid-XFER: on the next cycle expect all outputs 0, state IDLE and rr_ptr 0.

Source files
------------

// File: rtl/sm3_pkg.sv
// Shared SM3 front-end types: arbiter FSM state encoding, digest width, input bus width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sm3_pkg;

    localparam int SM3_DGST_W = 256;

    // Message bus width follows the build define shared with the pad core.
`ifdef SM3_INPT_DW_64
    localparam int SM3_INPT_DW = 64;
`else
    localparam int SM3_INPT_DW = 32;
`endif

    // Arbiter FSM state, kept as plain 2-bit constants for legacy tooling.
    typedef logic [1:0] sm3_state_t;

    localparam sm3_state_t ST_IDLE = 2'd0;
    localparam sm3_state_t ST_XFER = 2'd1;
    localparam sm3_state_t ST_WAIT = 2'd2;
    localparam sm3_state_t ST_RESP = 2'd3;

endpackage

// File: rtl/sm3_rr_sel.sv
// Round-robin picker: first asserted req scanning rr_ptr, rr_ptr+1, ... modulo REQ_NUM.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is pending.
// Ports: req (request vector), rr_ptr (highest-priority index) -> id (winner), found.
module sm3_rr_sel #(
    parameter int REQ_NUM = 4,
    parameter int ID_W    = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    id,
    output logic               found
);

    int idx;

    // Scan from the farthest offset down to rr_ptr so the closest match wins last.
    always_comb begin
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % REQ_NUM;
            if (req[idx]) begin
                id    = ID_W'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm3_msg_arb.sv
// Arbitrates REQ_NUM message sources onto one SM3 pad/expand/compress pipeline, returns digest with owner id.
// Latency: grant 1 cycle after req_vld in IDLE; beats pass combinationally; digest registered 1 cycle after compress pulse.
// Backpressure: req_rdy of the owner follows msg_inpt_rdy; the digest is held in RESP until res_rdy.
// Ports: req_* (requester beats), msg_inpt_* (to pad core), cmprss_otpt_* (from compress core),
//        res_* (digest back to requester), busy, err_unexp_res (digest pulse outside WAIT).
module sm3_msg_arb
    import sm3_pkg::*;
#(
    parameter int REQ_NUM = 4,
    parameter int INPT_DW = SM3_INPT_DW,
    parameter int ID_W    = $clog2(REQ_NUM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REQ_NUM-1:0]        req_vld,
    input  logic [REQ_NUM*INPT_DW-1:0] req_d,
    input  logic [REQ_NUM*INPT_DW/8-1:0] req_vld_byte,
    input  logic [REQ_NUM-1:0]        req_lst,
    output logic [REQ_NUM-1:0]        req_rdy,
    output logic                      msg_inpt_vld,
    output logic [INPT_DW-1:0]        msg_inpt_d,
    output logic [INPT_DW/8-1:0]      msg_inpt_vld_byte,
    output logic                      msg_inpt_lst,
    input  logic                      msg_inpt_rdy,
    input  logic                      cmprss_otpt_vld,
    input  logic [SM3_DGST_W-1:0]     cmprss_otpt_res,
    output logic                      res_vld,
    output logic [SM3_DGST_W-1:0]     res_d,
    output logic [ID_W-1:0]           res_id,
    input  logic                      res_rdy,
    output logic                      busy,
    output logic                      err_unexp_res
);

    localparam int BW = INPT_DW / 8;

    sm3_state_t              state;
    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         gnt_id;
    logic [SM3_DGST_W-1:0]   res_d_q;
    logic                    err_q;

    logic [ID_W-1:0]         sel_id;
    logic                    sel_found;
    logic                    lst_acc;

    sm3_rr_sel #(
        .REQ_NUM (REQ_NUM),
        .ID_W    (ID_W)
    ) u_rr_sel (
        .req    (req_vld),
        .rr_ptr (rr_ptr),
        .id     (sel_id),
        .found  (sel_found)
    );

    // Only the owner's lane is visible to the pad core, and only while in XFER.
    always_comb begin
        msg_inpt_vld      = 1'b0;
        msg_inpt_d        = '0;
        msg_inpt_vld_byte = '0;
        msg_inpt_lst      = 1'b0;
        req_rdy           = '0;
        if (state == ST_XFER) begin
            msg_inpt_vld      = req_vld[int'(gnt_id)];
            msg_inpt_d        = req_d[int'(gnt_id)*INPT_DW +: INPT_DW];
            msg_inpt_vld_byte = req_vld_byte[int'(gnt_id)*BW +: BW];
            msg_inpt_lst      = req_lst[int'(gnt_id)];
            req_rdy[int'(gnt_id)] = msg_inpt_rdy;
        end
    end

    assign lst_acc       = msg_inpt_vld & msg_inpt_rdy & msg_inpt_lst;
    assign res_vld       = (state == ST_RESP);
    assign res_id        = res_vld ? gnt_id : '0;
    assign res_d         = res_d_q;
    assign busy          = (state != ST_IDLE);
    assign err_unexp_res = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            gnt_id  <= '0;
            res_d_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // A stray digest only flags; it never disturbs state or the held result.
            err_q <= cmprss_otpt_vld && (state != ST_WAIT);
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        gnt_id <= sel_id;
                        state  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (lst_acc) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cmprss_otpt_vld) begin
                        res_d_q <= cmprss_otpt_res;
                        state   <= ST_RESP;
                    end
                end
                default: begin
                    if (res_rdy) begin
                        state  <= ST_IDLE;
                        // The requester just served drops to lowest priority.
                        rr_ptr <= (gnt_id == ID_W'(REQ_NUM - 1)) ? '0 : gnt_id + ID_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm3_msg_arb.sv
module tb_sm3_msg_arb;
    import sm3_pkg::*;

    localparam int RN = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    localparam logic [255:0] DG_ABC =
        256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] DG_16 =
        256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

    logic              clk = 1'b0;
    logic              rst;
    logic [RN-1:0]     req_vld;
    logic [RN*DW-1:0]  req_d;
    logic [RN*DW/8-1:0] req_vld_byte;
    logic [RN-1:0]     req_lst;
    logic [RN-1:0]     req_rdy;
    logic              msg_inpt_vld;
    logic [DW-1:0]     msg_inpt_d;
    logic [DW/8-1:0]   msg_inpt_vld_byte;
    logic              msg_inpt_lst;
    logic              msg_inpt_rdy;
    logic              cmprss_otpt_vld;
    logic [255:0]      cmprss_otpt_res;
    logic              res_vld;
    logic [255:0]      res_d;
    logic [IW-1:0]     res_id;
    logic              res_rdy;
    logic              busy;
    logic              err_unexp_res;

    int n_cmp = 0;
    int n_err = 0;
    int beat_cnt = 0;
    int lst_cnt = 0;

    sm3_msg_arb #(.REQ_NUM(RN), .INPT_DW(DW), .ID_W(IW)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_vld           (req_vld),
        .req_d             (req_d),
        .req_vld_byte      (req_vld_byte),
        .req_lst           (req_lst),
        .req_rdy           (req_rdy),
        .msg_inpt_vld      (msg_inpt_vld),
        .msg_inpt_d        (msg_inpt_d),
        .msg_inpt_vld_byte (msg_inpt_vld_byte),
        .msg_inpt_lst      (msg_inpt_lst),
        .msg_inpt_rdy      (msg_inpt_rdy),
        .cmprss_otpt_vld   (cmprss_otpt_vld),
        .cmprss_otpt_res   (cmprss_otpt_res),
        .res_vld           (res_vld),
        .res_d             (res_d),
        .res_id            (res_id),
        .res_rdy           (res_rdy),
        .busy              (busy),
        .err_unexp_res     (err_unexp_res)
    );

    always #5 clk = ~clk;

    // Pad-core side beat counter.
    always @(posedge clk) begin
        if (!rst && msg_inpt_vld && msg_inpt_rdy) begin
            beat_cnt = beat_cnt + 1;
            if (msg_inpt_lst) lst_cnt = lst_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] d,
                           input logic [3:0] vb, input logic l);
        req_vld[i]             = v;
        req_d[i*DW +: DW]      = d;
        req_vld_byte[i*4 +: 4] = vb;
        req_lst[i]             = l;
    endtask

    // Entered in WAIT: plays the compress core, then accepts the response.
    task automatic finish_msg(input logic [255:0] dg, input int id, input string tag);
        n_cmp++;
        if (dut.state !== ST_WAIT) begin
            n_err++; $display("FAIL %s_wait: state=%0d expected=%0d", tag, dut.state, ST_WAIT);
        end
        n_cmp++;
        if (msg_inpt_vld !== 1'b0) begin
            n_err++; $display("FAIL %s_wait_vld: msg_inpt_vld=%b expected=0", tag, msg_inpt_vld);
        end
        cmprss_otpt_vld = 1'b1;
        cmprss_otpt_res = dg;
        tick();
        cmprss_otpt_vld = 1'b0;
        cmprss_otpt_res = '0;
        n_cmp++;
        if (res_vld !== 1'b1 || res_id !== IW'(id)) begin
            n_err++; $display("FAIL %s_resp: res_vld=%b res_id=%0d expected 1/%0d", tag, res_vld, res_id, id);
        end
        n_cmp++;
        if (res_d !== dg) begin
            n_err++; $display("FAIL %s_digest: res_d=%h expected=%h", tag, res_d, dg);
        end
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        n_cmp++;
        if (dut.state !== ST_IDLE || dut.rr_ptr !== IW'((id + 1) % RN)) begin
            n_err++; $display("FAIL %s_done: state=%0d rr_ptr=%0d expected 0/%0d",
                              tag, dut.state, dut.rr_ptr, (id + 1) % RN);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (dut.state !== ST_IDLE || dut.rr_ptr !== 2'd0 || dut.gnt_id !== 2'd0) begin
            n_err++; $display("FAIL reset_state: state=%0d rr_ptr=%0d gnt_id=%0d expected 0/0/0",
                              dut.state, dut.rr_ptr, dut.gnt_id);
        end
        n_cmp++;
        if ({msg_inpt_vld, msg_inpt_d, msg_inpt_vld_byte, msg_inpt_lst, req_rdy} !== '0) begin
            n_err++; $display("FAIL reset_bus: vld=%b d=%h rdy=%b expected all 0", msg_inpt_vld, msg_inpt_d, req_rdy);
        end
        n_cmp++;
        if ({res_vld, res_d, res_id, busy, err_unexp_res} !== '0) begin
            n_err++; $display("FAIL reset_res: res_vld=%b res_d=%h busy=%b err=%b expected all 0",
                              res_vld, res_d, busy, err_unexp_res);
        end
    endtask

    task automatic test_abc;
        msg_inpt_rdy = 1'b1;
        set_req(0, 1'b1, 32'h61626300, 4'b1110, 1'b1);
        #1;
        n_cmp++;
        if (req_rdy !== 4'b0000 || msg_inpt_vld !== 1'b0) begin
            n_err++; $display("FAIL abc_idle: req_rdy=%b msg_inpt_vld=%b expected 0000/0", req_rdy, msg_inpt_vld);
        end
        tick();
        n_cmp++;
        if (msg_inpt_vld !== 1'b1 || msg_inpt_d !== 32'h61626300 || msg_inpt_vld_byte !== 4'b1110
            || msg_inpt_lst !== 1'b1) begin
            n_err++; $display("FAIL abc_beat: vld=%b d=%h vb=%b lst=%b expected 1/61626300/1110/1",
                              msg_inpt_vld, msg_inpt_d, msg_inpt_vld_byte, msg_inpt_lst);
        end
        n_cmp++;
        if (req_rdy !== 4'b0001) begin
            n_err++; $display("FAIL abc_rdy: req_rdy=%b expected=0001", req_rdy);
        end
        tick();
        set_req(0, 1'b0, 32'h0, 4'h0, 1'b0);
        finish_msg(DG_ABC, 0, "abc");
    endtask

    task automatic test_16beat;
        beat_cnt = 0;
        lst_cnt  = 0;
        set_req(2, 1'b1, 32'h61626364, 4'hF, 1'b0);
        tick();
        for (int b = 0; b < 16; b++) begin
            req_lst[2] = (b == 15);
            #1;
            if (b == 0) begin
                n_cmp++;
                if (req_rdy !== 4'b0100) begin
                    n_err++; $display("FAIL b16_rdy: req_rdy=%b expected=0100", req_rdy);
                end
            end
            tick();
        end
        set_req(2, 1'b0, 32'h0, 4'h0, 1'b0);
        n_cmp++;
        if (beat_cnt !== 16 || lst_cnt !== 1) begin
            n_err++; $display("FAIL b16_count: beats=%0d lst=%0d expected 16/1", beat_cnt, lst_cnt);
        end
        finish_msg(DG_16, 2, "b16");
    endtask

    task automatic test_rr_order;
        int exp_ids[4] = '{0, 1, 3, 0};
        logic [3:0]  oh;
        logic [31:0] ed;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 32'hA0000000, 4'hF, 1'b1);
        set_req(1, 1'b1, 32'hA0000001, 4'hF, 1'b1);
        set_req(3, 1'b1, 32'hA0000003, 4'hF, 1'b1);
        for (int n = 0; n < 4; n++) begin
            for (int t = 0; t < 4 && dut.state !== ST_XFER; t++) tick();
            oh = 4'b0001 << exp_ids[n];
            ed = 32'hA0000000 | 32'(exp_ids[n]);
            n_cmp++;
            if (dut.state !== ST_XFER || msg_inpt_d !== ed) begin
                n_err++; $display("FAIL rr_grant%0d: state=%0d d=%h expected 1/%h", n, dut.state, msg_inpt_d, ed);
            end
            n_cmp++;
            if (req_rdy !== oh) begin
                n_err++; $display("FAIL rr_rdy%0d: req_rdy=%b expected=%b", n, req_rdy, oh);
            end
            tick();
            n_cmp++;
            if (req_rdy !== 4'b0000) begin
                n_err++; $display("FAIL rr_rdy_wait%0d: req_rdy=%b expected=0000", n, req_rdy);
            end
            finish_msg(DG_ABC, exp_ids[n], "rr");
        end
        req_vld = '0;
        req_lst = '0;
    endtask

    task automatic test_backpressure;
        int  sent = 0;
        logic acc;
        beat_cnt = 0;
        lst_cnt  = 0;
        set_req(2, 1'b0, 32'h61626364, 4'hF, 1'b0);
        for (int cyc = 0; cyc < 400 && sent < 16; cyc++) begin
            req_vld[2]   = ($urandom_range(0, 3) != 0);
            req_lst[2]   = (sent == 15);
            msg_inpt_rdy = ($urandom_range(0, 1) == 1);
            #1;
            acc = req_vld[2] & req_rdy[2];
            tick();
            if (acc) sent++;
        end
        set_req(2, 1'b0, 32'h0, 4'h0, 1'b0);
        msg_inpt_rdy = 1'b1;
        n_cmp++;
        if (sent !== 16 || beat_cnt !== 16 || lst_cnt !== 1) begin
            n_err++; $display("FAIL bp_count: sent=%0d beats=%0d lst=%0d expected 16/16/1", sent, beat_cnt, lst_cnt);
        end
        finish_msg(DG_16, 2, "bp");
    endtask

    task automatic test_resp_hold;
        int bad = 0;
        set_req(1, 1'b1, 32'hB1, 4'hF, 1'b1);
        tick();
        tick();
        set_req(1, 1'b0, 32'h0, 4'h0, 1'b0);
        cmprss_otpt_vld = 1'b1;
        cmprss_otpt_res = DG_ABC;
        tick();
        cmprss_otpt_vld = 1'b0;
        cmprss_otpt_res = '0;
        set_req(3, 1'b1, 32'hB3, 4'hF, 1'b1);
        for (int c = 0; c < 20; c++) begin
            if (res_vld !== 1'b1 || res_d !== DG_ABC || res_id !== 2'd1 || dut.state !== ST_RESP
                || req_rdy !== 4'b0000 || msg_inpt_vld !== 1'b0) bad++;
            tick();
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++; $display("FAIL hold_stable: unstable cycles=%0d expected=0", bad);
        end
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        n_cmp++;
        if (dut.state !== ST_IDLE || dut.rr_ptr !== 2'd2) begin
            n_err++; $display("FAIL hold_release: state=%0d rr_ptr=%0d expected 0/2", dut.state, dut.rr_ptr);
        end
        tick();
        n_cmp++;
        if (dut.state !== ST_XFER || msg_inpt_d !== 32'hB3 || req_rdy !== 4'b1000) begin
            n_err++; $display("FAIL hold_regrant: state=%0d d=%h rdy=%b expected 1/b3/1000",
                              dut.state, msg_inpt_d, req_rdy);
        end
        tick();
        set_req(3, 1'b0, 32'h0, 4'h0, 1'b0);
        finish_msg(DG_16, 3, "hold3");
    endtask

    task automatic test_err_reset;
        set_req(0, 1'b1, 32'hC0, 4'hF, 1'b0);
        tick();
        cmprss_otpt_vld = 1'b1;
        cmprss_otpt_res = {8{32'hDEADBEEF}};
        tick();
        cmprss_otpt_vld = 1'b0;
        cmprss_otpt_res = '0;
        n_cmp++;
        if (err_unexp_res !== 1'b1 || dut.state !== ST_XFER) begin
            n_err++; $display("FAIL err_pulse: err=%b state=%0d expected 1/1", err_unexp_res, dut.state);
        end
        n_cmp++;
        if (res_d !== DG_16) begin
            n_err++; $display("FAIL err_res_kept: res_d=%h expected=%h", res_d, DG_16);
        end
        tick();
        n_cmp++;
        if (err_unexp_res !== 1'b0 || dut.state !== ST_XFER) begin
            n_err++; $display("FAIL err_single: err=%b state=%0d expected 0/1", err_unexp_res, dut.state);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (dut.state !== ST_IDLE || dut.rr_ptr !== 2'd0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rst_state: state=%0d rr_ptr=%0d busy=%b expected 0/0/0",
                              dut.state, dut.rr_ptr, busy);
        end
        n_cmp++;
        if ({msg_inpt_vld, msg_inpt_d, msg_inpt_vld_byte, msg_inpt_lst, req_rdy,
             res_vld, res_d, res_id, err_unexp_res} !== '0) begin
            n_err++; $display("FAIL rst_outputs: vld=%b rdy=%b res_vld=%b res_d=%h expected all 0",
                              msg_inpt_vld, req_rdy, res_vld, res_d);
        end
        rst = 1'b0;
        set_req(0, 1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    initial begin
        rst             = 1'b1;
        req_vld         = '0;
        req_d           = '0;
        req_vld_byte    = '0;
        req_lst         = '0;
        msg_inpt_rdy    = 1'b0;
        cmprss_otpt_vld = 1'b0;
        cmprss_otpt_res = '0;
        res_rdy         = 1'b0;
        test_reset();
        test_abc();
        test_16beat();
        test_rr_order();
        test_backpressure();
        test_resp_hold();
        test_err_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
